serial_output: RTL and testbench
================================

Name: serial_output

Overview:
- Transmit-side UART (8N1) that drains the 32-bit stb/ack stream driving the RS-232 TX pin of the board.
- Acts as the sink/responder for the user design's rs232 TX output stream. Accepts one word per handshake and serialises its low byte LSB-first onto the line.
- Sits between the user design's rs232 output stream and the FPGA TX pad. It is the transmit counterpart of the existing serial input block.

Parameters:
- CLOCK_FREQUENCY, 50000000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- Derived localparam CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division, truncating). Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- input_rs232_tx  input  32  data word; bits [7:0] are transmitted, [31:8] are ignored.
- input_rs232_tx_stb  input  1  source asserts while the word is valid; held until ack is seen.
- input_rs232_tx_ack  output  1  one-cycle acceptance pulse.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst=1 sampled at a clock edge): tx=1, ack=0, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame. tx returns to 1 on the next edge, and the partially sent byte is discarded.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - tx=1.
  - If stb=1 at edge N, then at edge N+1: ack=1, byte latched from input_rs232_tx[7:0], tx=0, state=START, counter=0.
  - ack returns to 0 at edge N+2.
  - stb is sampled only in IDLE and only while ack=0. This prevents a double accept of the same word.
- Bit timing: every line bit lasts exactly CLOCKS_PER_BIT cycles.
  - The counter counts 0..CLOCKS_PER_BIT-1.
  - On the terminal count the counter wraps to 0 and the state/bit advances.
- START: tx=0 for one bit time, then DATA with bit index 0.
- DATA:
  - tx = byte[index].
  - After each bit time, index increments.
  - After index 7 completes, go to PARITY (if enabled) or STOP. Index wraps to 0.
- STOP: tx=1 for one bit time, then IDLE.
- Back-to-back:
  - A stb held high while busy is accepted on the first IDLE cycle after STOP.
  - Minimum frame spacing is therefore 1 idle clk. Frame length is 10*CLOCKS_PER_BIT cycles (11 with parity).
  - Accept-to-accept period is 10*CLOCKS_PER_BIT + 1 cycles.
- stb deasserted before ack: nothing is sent and there is no error.
- stb must not be deasserted in the same cycle ack rises. Source behaviour after ack is the source's concern.
- No input buffering beyond the single latched byte. Backpressure is purely via withheld ack.

Optional Feature:
- Macro: SERIAL_OUTPUT_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives tx = XOR of the 8 data bits (even parity) for one bit time. The frame becomes 8E1, 11 bit times.
- Undefined: the PARITY state and its logic are absent. The frame is 8N1, 10 bit times.

Decomposition:
- Shared package serial_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - The constants DATA_BITS=8 and STREAM_WIDTH=32, plus a function computing CLOCKS_PER_BIT.
  - The serial input block shares the same package.
- One natural sub-module: serial_baud_counter.
  - Parameterised on CLOCKS_PER_BIT.
  - Inputs: clk, rst, clear. Output: bit_done pulse on the terminal count.
  - Reused by the receiver.

Test Plan:
- Use CLOCK_FREQUENCY=8, BAUD_RATE=1 (8 clk/bit). Send word 0x00000055 -> ack is high exactly 1 cycle after stb is sampled. tx = 0, then 1,0,1,0,1,0,1,0 (LSB first), then 1; each level lasts 8 cycles; total 80 cycles, then tx stays 1.
- Send 0xFFFFFF00 -> tx = start 0, eight 0 data bits, stop 1. Upper bits are ignored.
- Hold stb high with 0x41 then 0x42 (source swaps data after ack) -> two frames. The second ack arrives exactly 81 cycles after the first, and the decoded bytes are 0x41 and 0x42.
- Assert rst for 1 cycle during data bit 3 of 0xA5 -> tx=1 and ack=0 on the next edge. A subsequent 0x3C is sent as a complete, correct frame.
- Pulse stb for 1 cycle with 0x10 while busy mid-frame -> no ack is generated and no extra frame is sent.
- With SERIAL_OUTPUT_PARITY_EN defined, send 0x07 -> the parity bit is 1 and the frame is 88 cycles. With 0x03 the parity bit is 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks: FSM states, stream payload layout,
// and bit-timing helper.
package serial_pkg;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned STREAM_WIDTH = 32;
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);
    localparam int unsigned PAD_BITS     = STREAM_WIDTH - DATA_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serial_state_e;

    // Stream word as seen on the rs232 ports; only the low byte travels on the line.
    typedef struct packed {
        logic [PAD_BITS-1:0]  pad;
        logic [DATA_BITS-1:0] data;
    } rs232_word_t;

    function automatic int unsigned clocks_per_bit(input int unsigned clock_frequency,
                                                   input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-time counter: counts 0..CLOCKS_PER_BIT-1 and flags the terminal count with a registered pulse.
module serial_baud_counter #(
    parameter int unsigned CLOCKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // done_q mirrors (cnt_q == TERMINAL) so the pulse is registered yet aligned with the count.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == TERMINAL)) begin
            cnt_d = '0;
        end
        done_d = !clear && (cnt_d == TERMINAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bit_done = done_q;

endmodule

// File: rtl/serial_output.sv
// UART transmitter draining the rs232 TX stb/ack stream; 8N1 by default,
// 8E1 when SERIAL_OUTPUT_PARITY_EN is defined.
module serial_output
    import serial_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 115200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STREAM_WIDTH-1:0] input_rs232_tx,
    input  logic                    input_rs232_tx_stb,
    output logic                    input_rs232_tx_ack,
    output logic                    tx
);

    localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);

    serial_state_e        state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 bit_done;
    logic                 baud_clear_c;
    rs232_word_t          word_c;
    logic                 unused_pad_c;

    assign word_c       = rs232_word_t'(input_rs232_tx);
    assign unused_pad_c = ^word_c.pad;

    // Counter is held at zero while idle so the start bit gets a full bit time from accept.
    assign baud_clear_c = (state_q == IDLE);

    serial_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear_c),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        data_d  = data_q;
        idx_d   = idx_q;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (input_rs232_tx_stb && !ack_q) begin
                    state_d = START;
                    ack_d   = 1'b1;
                    data_d  = word_c.data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d = '0;
`ifdef SERIAL_OUTPUT_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_OUTPUT_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is derived from the upcoming state so tx is registered with no extra lag.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
`ifdef SERIAL_OUTPUT_PARITY_EN
            PARITY:  tx_d = ^data_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            tx_q    <= 1'b1;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign input_rs232_tx_ack = ack_q;
    assign tx                 = tx_q;

endmodule

// File: tb/tb_serial_output.sv
// Directed bench for serial_output at 8 clk/bit; define SERIAL_OUTPUT_PARITY_EN to cover 8E1.
module tb_serial_output;

    localparam int CPB = 8;
`ifdef SERIAL_OUTPUT_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] word;
    logic        stb;
    logic        ack;
    logic        tx;

    int errors;
    int checks;

    serial_output #(
        .CLOCK_FREQUENCY(8),
        .BAUD_RATE      (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_rs232_tx    (word),
        .input_rs232_tx_stb(stb),
        .input_rs232_tx_ack(ack),
        .tx                (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word in IDLE; ack must be high right after the next edge.
    task automatic start_tx(input string tag, input logic [31:0] w);
        word = w;
        stb  = 1'b1;
        check({tag, "_ack_pre"}, 32'(ack), 32'd0);
        tick();
        check({tag, "_ack_lat"}, 32'(ack), 32'd1);
    endtask

    // Called on the cycle ack is high; samples the whole frame and the first idle cycle after it.
    task automatic run_frame(input string tag, input logic [7:0] exp_byte, input logic exp_par,
                             input int pulse_at, input logic hold_stb, input logic [31:0] hold_word);
        logic [10:0] bits;
        logic        stable;
        int          ack_seen;
        int          k;
        bits     = '0;
        stable   = 1'b1;
        ack_seen = 0;
        k        = 0;
        if (hold_stb) word = hold_word;
        else stb = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
                if (ack === 1'b1) ack_seen++;
                if (k == pulse_at) begin
                    word = 32'h0000_0010;
                    stb  = 1'b1;
                end else if (k == pulse_at + 1) begin
                    stb = 1'b0;
                end
                k++;
                tick();
            end
        end
        check({tag, "_start"}, 32'(bits[0]), 32'd0);
        check({tag, "_byte"}, 32'(bits[8:1]), 32'(exp_byte));
`ifdef SERIAL_OUTPUT_PARITY_EN
        check({tag, "_parity"}, 32'(bits[9]), 32'(exp_par));
`else
        if (exp_par !== 1'b0) check({tag, "_parity_arg"}, 32'(exp_par), 32'd0);
`endif
        check({tag, "_stop"}, 32'(bits[NB-1]), 32'd1);
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_ack_cnt"}, 32'(ack_seen), 32'd1);
        check({tag, "_idle_tx"}, 32'(tx), 32'd1);
        check({tag, "_idle_ack"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int gap;
        int bad;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        stb    = 1'b0;
        word   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        tick();

        // 0x55: alternating data bits, LSB first.
        start_tx("f55", 32'h0000_0055);
        run_frame("f55", 8'h55, 1'b0, -10, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx !== 1'b1 || ack !== 1'b0) bad++;
            tick();
        end
        check("f55_after_idle", 32'(bad), 32'd0);

        // Upper stream bits must not leak onto the line.
        start_tx("f00", 32'hFFFF_FF00);
        run_frame("f00", 8'h00, 1'b0, -10, 1'b0, '0);
        tick();

        // Back-to-back with stb held; source swaps data after the first ack.
        start_tx("b41", 32'h0000_0041);
        run_frame("b41", 8'h41, 1'b0, -10, 1'b1, 32'h0000_0042);
        gap = NB * CPB;
        for (int i = 0; i < 5 && ack !== 1'b1; i++) begin
            tick();
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'(NB * CPB + 1));
        run_frame("b42", 8'h42, 1'b0, -10, 1'b0, '0);
        tick();

        // Reset during data bit 3 of 0xA5 (bit 3 is 0).
        start_tx("fa5", 32'h0000_00A5);
        stb = 1'b0;
        for (int i = 0; i < 4 * CPB + 2; i++) tick();
        check("a5_bit3_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("a5_rst_tx", 32'(tx), 32'd1);
        check("a5_rst_ack", 32'(ack), 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || ack !== 1'b0) bad++;
            tick();
        end
        check("a5_abort_idle", 32'(bad), 32'd0);
        start_tx("f3c", 32'h0000_003C);
        run_frame("f3c", 8'h3C, 1'b0, -10, 1'b0, '0);
        tick();

        // One-cycle stb pulse while busy must be ignored.
        start_tx("f81", 32'h0000_0081);
        run_frame("f81", 8'h81, 1'b0, 20, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || ack !== 1'b0) bad++;
            tick();
        end
        check("f81_no_extra", 32'(bad), 32'd0);

`ifdef SERIAL_OUTPUT_PARITY_EN
        start_tx("p07", 32'h0000_0007);
        run_frame("p07", 8'h07, 1'b1, -10, 1'b0, '0);
        tick();
        start_tx("p03", 32'h0000_0003);
        run_frame("p03", 8'h03, 1'b0, -10, 1'b0, '0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
